// File: rtl/mac_pkg.sv
// Shared command codes and request-word field layout for the memory access controller.
// The arbiter, the controller top and the SDRAM sequencer all import this package.
package mac_pkg;

    localparam int REQ_W   = 45;
    localparam int ADDR_LSB = 13;
    localparam int ADDR_W   = 32;
    localparam int TAG_LSB  = 9;
    localparam int TAG_W    = 4;
    localparam int ID_LSB   = 6;
    localparam int ID_W     = 3;
    localparam int LEN_LSB  = 4;
    localparam int LEN_W    = 2;
    localparam int QOS_LSB  = 0;
    localparam int QOS_W    = 4;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'b000,
        CMD_READA   = 3'b001,
        CMD_WRITEA  = 3'b010,
        CMD_REFRESH = 3'b011
    } cmd_e;

    typedef logic [REQ_W-1:0] req_t;

    function automatic logic [ADDR_W-1:0] reqAddr(input req_t r);
        return r[ADDR_LSB +: ADDR_W];
    endfunction

    function automatic logic [TAG_W-1:0] reqTag(input req_t r);
        return r[TAG_LSB +: TAG_W];
    endfunction

    function automatic logic [ID_W-1:0] reqId(input req_t r);
        return r[ID_LSB +: ID_W];
    endfunction

    function automatic logic [LEN_W-1:0] reqLen(input req_t r);
        return r[LEN_LSB +: LEN_W];
    endfunction

    function automatic logic [QOS_W-1:0] reqQos(input req_t r);
        return r[QOS_LSB +: QOS_W];
    endfunction

endpackage

// File: rtl/mac_req_arbiter_if.sv
// Bundle of the request-FIFO read ports and the command valid/ready bus around the arbiter.
// master = arbiter side, slave = FIFOs/sequencer side.
interface mac_req_arbiter_if;
    import mac_pkg::*;

    logic                iArbEn;
    logic                iWrEmpty;
    logic                oWrRd;
    req_t                iWrData;
    logic                iRdEmpty;
    logic                oRdRd;
    req_t                iRdData;
    logic                oCmdValid;
    logic                iCmdReady;
    cmd_e                oCmd;
    logic [ADDR_W-1:0]   oCmdAddr;
    logic [TAG_W-1:0]    oCmdTag;
    logic [ID_W-1:0]     oCmdId;
    logic [LEN_W-1:0]    oCmdLen;
    logic                oRefOverrun;

    modport master (
        input  iArbEn, iWrEmpty, iWrData, iRdEmpty, iRdData, iCmdReady,
        output oWrRd, oRdRd, oCmdValid, oCmd, oCmdAddr, oCmdTag, oCmdId, oCmdLen, oRefOverrun
    );

    modport slave (
        output iArbEn, iWrEmpty, iWrData, iRdEmpty, iRdData, iCmdReady,
        input  oWrRd, oRdRd, oCmdValid, oCmd, oCmdAddr, oCmdTag, oCmdId, oCmdLen, oRefOverrun
    );

endinterface

// File: rtl/mac_req_prefetch.sv
// One request channel: keeps a single prefetched FIFO head, issues the FIFO read pulse
// and tracks how many grants this head has lost while waiting.
module mac_req_prefetch
    import mac_pkg::*;
#(
    parameter int AGE_W   = 4,
    parameter int AGE_MAX = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_fifoEmpty,
    output logic o_fifoRd,
    input  req_t i_fifoData,
    input  logic i_grant,
    input  logic i_grantOther,
    output req_t o_head,
    output logic o_headValid,
    output logic o_urgent
);

    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

    logic             r_inflight;
    logic             r_headValid;
    req_t             r_head;
    logic [AGE_W-1:0] r_age;
    logic             w_rd;

    // A granted head is consumed this cycle, so its replacement can be requested immediately.
    assign w_rd = !i_fifoEmpty && !r_inflight && (!r_headValid || i_grant);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inflight  <= 1'b0;
            r_headValid <= 1'b0;
            r_head      <= '0;
            r_age       <= '0;
        end else begin
            r_inflight <= w_rd;
            if (r_inflight) begin
                r_head      <= i_fifoData;
                r_headValid <= 1'b1;
            end else if (i_grant) begin
                r_headValid <= 1'b0;
            end
            if (i_grant) begin
                r_age <= '0;
            end else if (i_grantOther && r_headValid && (r_age != '1)) begin
                r_age <= r_age + 1'b1;
            end
        end
    end

    assign o_fifoRd    = w_rd;
    assign o_head      = r_head;
    assign o_headValid = r_headValid;
    assign o_urgent    = r_headValid && (r_age >= AGE_LIM);

    aNoReadWhenEmpty : assert property (@(posedge clk) disable iff (!resetn) o_fifoRd |-> !i_fifoEmpty);

endmodule

// File: rtl/mac_req_arbiter.sv
// Picks one SDRAM command per grant from the write/read request heads and the refresh timer.
// Priority: refresh, then a lone starved head, then higher QoS, with round-robin on ties.
module mac_req_arbiter
    import mac_pkg::*;
#(
    parameter int REF_INTERVAL = 780,
    parameter int AGE_MAX      = 8,
    parameter int AGE_W        = 4
) (
    input  logic              clk,
    input  logic              resetn,
    mac_req_arbiter_if.master bus
);

    localparam int                RC_W       = $clog2(REF_INTERVAL);
    localparam logic [RC_W-1:0]   REF_RELOAD = RC_W'(REF_INTERVAL - 1);

    req_t              w_wrHead;
    req_t              w_rdHead;
    logic              w_wrValid;
    logic              w_rdValid;
    logic              w_wrUrgent;
    logic              w_rdUrgent;
    logic              w_canGrant;
    logic              w_grantWr;
    logic              w_grantRd;
    logic              w_grantRef;
    logic              w_grant;
    logic              w_refExpire;
    cmd_e              w_nextCmd;
    req_t              w_winHead;

    logic              r_cmdValid;
    cmd_e              r_cmd;
    logic [ADDR_W-1:0] r_cmdAddr;
    logic [TAG_W-1:0]  r_cmdTag;
    logic [ID_W-1:0]   r_cmdId;
    logic [LEN_W-1:0]  r_cmdLen;
    logic              r_lastWr;
    logic [RC_W-1:0]   r_refCnt;
    logic              r_refPending;
    logic              r_refOverrun;

    mac_req_prefetch #(.AGE_W(AGE_W), .AGE_MAX(AGE_MAX)) uWrPrefetch (
        .clk          (clk),
        .resetn       (resetn),
        .i_fifoEmpty  (bus.iWrEmpty),
        .o_fifoRd     (bus.oWrRd),
        .i_fifoData   (bus.iWrData),
        .i_grant      (w_grantWr),
        .i_grantOther (w_grantRd || w_grantRef),
        .o_head       (w_wrHead),
        .o_headValid  (w_wrValid),
        .o_urgent     (w_wrUrgent)
    );

    mac_req_prefetch #(.AGE_W(AGE_W), .AGE_MAX(AGE_MAX)) uRdPrefetch (
        .clk          (clk),
        .resetn       (resetn),
        .i_fifoEmpty  (bus.iRdEmpty),
        .o_fifoRd     (bus.oRdRd),
        .i_fifoData   (bus.iRdData),
        .i_grant      (w_grantRd),
        .i_grantOther (w_grantWr || w_grantRef),
        .o_head       (w_rdHead),
        .o_headValid  (w_rdValid),
        .o_urgent     (w_rdUrgent)
    );

    assign w_canGrant  = (!r_cmdValid || bus.iCmdReady) && bus.iArbEn;
    assign w_grant     = w_grantWr || w_grantRd || w_grantRef;
    assign w_refExpire = bus.iArbEn && (r_refCnt == '0);

    always_comb begin
        w_grantWr  = 1'b0;
        w_grantRd  = 1'b0;
        w_grantRef = 1'b0;
        if (w_canGrant) begin
            if (r_refPending) begin
                w_grantRef = 1'b1;
            end else if (w_wrUrgent != w_rdUrgent) begin
                w_grantWr = w_wrUrgent;
                w_grantRd = w_rdUrgent;
            end else if ((w_wrUrgent && w_rdUrgent) ||
                         (w_wrValid && w_rdValid && (reqQos(w_wrHead) == reqQos(w_rdHead)))) begin
                w_grantWr = !r_lastWr;
                w_grantRd = r_lastWr;
            end else if (w_wrValid && w_rdValid) begin
                w_grantWr = reqQos(w_wrHead) > reqQos(w_rdHead);
                w_grantRd = !(reqQos(w_wrHead) > reqQos(w_rdHead));
            end else begin
                w_grantWr = w_wrValid;
                w_grantRd = w_rdValid;
            end
        end
    end

    always_comb begin
        w_winHead = w_grantWr ? w_wrHead : w_rdHead;
        w_nextCmd = w_grantRef ? CMD_REFRESH : (w_grantWr ? CMD_WRITEA : CMD_READA);
    end

    // Payload only reloads on a grant, which keeps it frozen while the sequencer stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cmdValid <= 1'b0;
            r_cmd      <= CMD_NOP;
            r_cmdAddr  <= '0;
            r_cmdTag   <= '0;
            r_cmdId    <= '0;
            r_cmdLen   <= '0;
        end else if (w_grant) begin
            r_cmdValid <= 1'b1;
            r_cmd      <= w_nextCmd;
            r_cmdAddr  <= w_grantRef ? '0 : reqAddr(w_winHead);
            r_cmdTag   <= w_grantRef ? '0 : reqTag(w_winHead);
            r_cmdId    <= w_grantRef ? '0 : reqId(w_winHead);
            r_cmdLen   <= w_grantRef ? '0 : reqLen(w_winHead);
        end else if (bus.iCmdReady) begin
            r_cmdValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lastWr <= 1'b1;
        end else if (w_grantWr) begin
            r_lastWr <= 1'b1;
        end else if (w_grantRd) begin
            r_lastWr <= 1'b0;
        end
    end

    // A refresh granted in the expiry cycle is replaced by the new one, so it is not an overrun.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_refCnt     <= REF_RELOAD;
            r_refPending <= 1'b0;
            r_refOverrun <= 1'b0;
        end else begin
            r_refOverrun <= w_refExpire && r_refPending && !w_grantRef;
            if (bus.iArbEn) begin
                r_refCnt <= w_refExpire ? REF_RELOAD : r_refCnt - 1'b1;
            end
            if (w_refExpire) begin
                r_refPending <= 1'b1;
            end else if (w_grantRef) begin
                r_refPending <= 1'b0;
            end
        end
    end

    assign bus.oCmdValid   = r_cmdValid;
    assign bus.oCmd        = r_cmd;
    assign bus.oCmdAddr    = r_cmdAddr;
    assign bus.oCmdTag     = r_cmdTag;
    assign bus.oCmdId      = r_cmdId;
    assign bus.oCmdLen     = r_cmdLen;
    assign bus.oRefOverrun = r_refOverrun;

endmodule
